// File: rtl/regfile_wb_arbiter_if.sv
// Bundles the issue, write-back and register-file signals of regfile_wb_arbiter.
//   slave  : the arbiter side (takes issue/write-back requests, drives readies,
//            the register-file write port, the scoreboard and the error flag)
//   master : the surrounding pipeline side (decode, ALU, load unit, register file)
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
);
    logic            issue_valid;
    logic [4:0]      issue_rs1;
    logic [4:0]      issue_rs2;
    logic [4:0]      issue_rd;
    logic            issue_ready;

    logic            alu_wb_valid;
    logic [4:0]      alu_wb_rd;
    logic [XLEN-1:0] alu_wb_data;
    logic            alu_wb_ready;

    logic            mem_wb_valid;
    logic [4:0]      mem_wb_rd;
    logic [XLEN-1:0] mem_wb_data;
    logic            mem_wb_ready;

    logic            flush;

    logic            rf_reg_write;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_write_data;
    logic [NREG-1:0] busy;
    logic            wb_err;

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  mem_wb_valid, mem_wb_rd, mem_wb_data,
        input  flush,
        output issue_ready, alu_wb_ready, mem_wb_ready,
        output rf_reg_write, rf_rd, rf_write_data, busy, wb_err
    );

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output mem_wb_valid, mem_wb_rd, mem_wb_data,
        output flush,
        input  issue_ready, alu_wb_ready, mem_wb_ready,
        input  rf_reg_write, rf_rd, rf_write_data, busy, wb_err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and register scoreboard.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : regfile_wb_arbiter_if.slave -- issue handshake, ALU/MEM write-back
//           requests, flush, registered register-file write port, busy
//           scoreboard and sticky wb_err flag
// One write-back is accepted per cycle (round-robin on conflict) and driven to
// the register file one cycle later; busy[rd] is set on issue and cleared when
// the write reaches the register file.
module regfile_wb_arbiter #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_wb_arbiter_if.slave bus
);

    logic            rr_ptr_q, rr_ptr_d;   // 0: ALU wins a conflict, 1: MEM wins
    logic [NREG-1:0] busy_q, busy_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic            wb_err_q, wb_err_d;
    logic            flush_q;              // flush seen in the previous cycle

    logic            alu_grant, mem_grant, accept;
    logic [4:0]      acc_rd;
    logic [XLEN-1:0] acc_data;
    logic [NREG-1:0] busy_eff;
    logic            issue_fire;

    // Arbitration
    always_comb begin
        alu_grant = bus.alu_wb_valid && (!bus.mem_wb_valid || !rr_ptr_q);
        mem_grant = bus.mem_wb_valid && (!bus.alu_wb_valid || rr_ptr_q);
        accept    = alu_grant || mem_grant;
        acc_rd    = mem_grant ? bus.mem_wb_rd   : bus.alu_wb_rd;
        acc_data  = mem_grant ? bus.mem_wb_data : bus.alu_wb_data;
        // Flip only on a conflict so the loser wins next time.
        rr_ptr_d  = (bus.alu_wb_valid && bus.mem_wb_valid) ? !rr_ptr_q : rr_ptr_q;
    end

    // Scoreboard and issue gating
    always_comb begin
        busy_eff    = busy_q;
        busy_eff[0] = 1'b0;

        bus.issue_ready = !bus.flush && !busy_eff[bus.issue_rs1]
                          && !busy_eff[bus.issue_rs2] && !busy_eff[bus.issue_rd];
        issue_fire      = bus.issue_valid && bus.issue_ready;

        busy_d = busy_q;
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            if (rf_we_q) busy_d[rf_rd_q] = 1'b0;
            // Set after clear: a fresh issue to the register being retired wins.
            if (issue_fire && bus.issue_rd != 5'd0) busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Register-file write port and error flag
    always_comb begin
        rf_we_d   = accept && (acc_rd != 5'd0);
        rf_rd_d   = accept ? acc_rd   : rf_rd_q;
        rf_data_d = accept ? acc_data : rf_data_q;
        // Writes landing during a flush or the cycle after may target registers
        // the flush already released, so they are not errors.
        wb_err_d  = wb_err_q || (accept && acc_rd != 5'd0 && !busy_eff[acc_rd]
                                 && !bus.flush && !flush_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q  <= 1'b0;
            busy_q    <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_q   <= 5'd0;
            rf_data_q <= '0;
            wb_err_q  <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            rf_we_q   <= rf_we_d;
            rf_rd_q   <= rf_rd_d;
            rf_data_q <= rf_data_d;
            wb_err_q  <= wb_err_d;
            flush_q   <= bus.flush;
        end
    end

    assign bus.alu_wb_ready  = alu_grant;
    assign bus.mem_wb_ready  = mem_grant;
    assign bus.rf_reg_write  = rf_we_q;
    assign bus.rf_rd         = rf_rd_q;
    assign bus.rf_write_data = rf_data_q;
    assign bus.busy          = busy_q;
    assign bus.wb_err        = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, issue/write-back scoreboard,
// round-robin arbitration, rd=0 writes, flush and asynchronous reset.
module tb_regfile_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.XLEN(64), .NREG(32)) bus ();

    regfile_wb_arbiter #(.XLEN(64), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.issue_valid  = 1'b0;
        bus.issue_rs1    = 5'd0;
        bus.issue_rs2    = 5'd0;
        bus.issue_rd     = 5'd0;
        bus.alu_wb_valid = 1'b0;
        bus.alu_wb_rd    = 5'd0;
        bus.alu_wb_data  = 64'd0;
        bus.mem_wb_valid = 1'b0;
        bus.mem_wb_rd    = 5'd0;
        bus.mem_wb_data  = 64'd0;
        bus.flush        = 1'b0;
    endtask

    logic [4:0]  exp_rd   [4] = '{5'd1, 5'd2, 5'd1, 5'd2};
    logic [63:0] exp_data [4] = '{64'h11, 64'h22, 64'h11, 64'h22};

    initial begin
        idle();
        #3;
        check("rst_busy",      64'(bus.busy),          64'h0);
        check("rst_rf_we",     64'(bus.rf_reg_write),  64'h0);
        check("rst_rf_rd",     64'(bus.rf_rd),         64'h0);
        check("rst_rf_data",   64'(bus.rf_write_data), 64'h0);
        check("rst_wb_err",    64'(bus.wb_err),        64'h0);
        #9 rst_n = 1'b1;

        // Issue rd=5, then ALU write-back to 5 with a dependent instruction waiting
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd5;
        #1;
        check("issue_rd5_ready", 64'(bus.issue_ready), 64'h1);
        tick();
        check("busy5_set", 64'(bus.busy), 64'h20);
        bus.issue_rs1    = 5'd5;
        bus.issue_rd     = 5'd6;
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd5;
        bus.alu_wb_data  = 64'hAB;
        #1;
        check("raw_blocked", 64'(bus.issue_ready),  64'h0);
        check("alu_lone_rdy", 64'(bus.alu_wb_ready), 64'h1);
        check("mem_idle_rdy", 64'(bus.mem_wb_ready), 64'h0);
        tick();
        bus.alu_wb_valid = 1'b0;
        check("wb5_we",      64'(bus.rf_reg_write),  64'h1);
        check("wb5_rd",      64'(bus.rf_rd),         64'h5);
        check("wb5_data",    64'(bus.rf_write_data), 64'hAB);
        check("wb5_busy",    64'(bus.busy),          64'h20);
        check("raw_still",   64'(bus.issue_ready),   64'h0);
        tick();
        check("after_wb_we",    64'(bus.rf_reg_write), 64'h0);
        check("busy5_cleared",  64'(bus.busy),         64'h0);
        check("raw_released",   64'(bus.issue_ready),  64'h1);
        tick();
        bus.issue_valid = 1'b0;
        check("busy6_set", 64'(bus.busy), 64'h40);

        // Asynchronous reset while a write to 6 is on the register-file port
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd6;
        bus.alu_wb_data  = 64'h66;
        tick();
        bus.alu_wb_valid = 1'b0;
        check("wb6_we",   64'(bus.rf_reg_write), 64'h1);
        check("wb6_busy", 64'(bus.busy),         64'h40);
        rst_n = 1'b0;
        #1;
        check("async_rst_we",   64'(bus.rf_reg_write), 64'h0);
        check("async_rst_busy", 64'(bus.busy),         64'h0);
        check("async_rst_rd",   64'(bus.rf_rd),        64'h0);
        #2 rst_n = 1'b1;

        // Both requesters valid for four cycles: ALU, MEM, ALU, MEM
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd1;
        bus.alu_wb_data  = 64'h11;
        bus.mem_wb_valid = 1'b1;
        bus.mem_wb_rd    = 5'd2;
        bus.mem_wb_data  = 64'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("rr_alu_rdy", 64'(bus.alu_wb_ready), 64'(i % 2 == 0));
            check("rr_mem_rdy", 64'(bus.mem_wb_ready), 64'(i % 2 == 1));
            tick();
            check("rr_rf_rd",   64'(bus.rf_rd),         64'(exp_rd[i]));
            check("rr_rf_data", 64'(bus.rf_write_data), exp_data[i]);
        end
        bus.alu_wb_valid = 1'b0;
        bus.mem_wb_valid = 1'b0;
        // Registers 1 and 2 were never issued
        check("unbusy_wb_err", 64'(bus.wb_err), 64'h1);
        rst_n = 1'b0;
        #1;
        check("rst_clears_err", 64'(bus.wb_err), 64'h0);
        #1 rst_n = 1'b1;

        // Write-back to x0
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd0;
        bus.alu_wb_data  = 64'h99;
        #1;
        check("x0_alu_rdy", 64'(bus.alu_wb_ready), 64'h1);
        tick();
        bus.alu_wb_valid = 1'b0;
        check("x0_we",     64'(bus.rf_reg_write),  64'h0);
        check("x0_data",   64'(bus.rf_write_data), 64'h99);
        check("x0_busy",   64'(bus.busy),          64'h0);
        check("x0_wb_err", 64'(bus.wb_err),        64'h0);

        // Clear busy[8] and set busy[9] on the same edge
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd8;
        tick();
        bus.issue_valid  = 1'b0;
        check("busy8_set", 64'(bus.busy), 64'h100);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd8;
        bus.alu_wb_data  = 64'h88;
        tick();
        bus.alu_wb_valid = 1'b0;
        check("wb8_rd", 64'(bus.rf_rd), 64'h8);
        bus.issue_valid  = 1'b1;
        bus.issue_rd     = 5'd9;
        #1;
        check("issue9_ready", 64'(bus.issue_ready), 64'h1);
        tick();
        bus.issue_valid = 1'b0;
        check("set9_clr8",   64'(bus.busy),   64'h200);
        check("wb8_no_err",  64'(bus.wb_err), 64'h0);

        // Flush with busy 3, 7, 9; write-backs during and just after are tolerated
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        tick();
        bus.issue_rd    = 5'd7;
        tick();
        bus.issue_valid = 1'b0;
        check("busy_3_7_9", 64'(bus.busy), 64'h288);
        bus.flush        = 1'b1;
        bus.issue_valid  = 1'b1;
        bus.issue_rd     = 5'd10;
        bus.mem_wb_valid = 1'b1;
        bus.mem_wb_rd    = 5'd3;
        bus.mem_wb_data  = 64'h33;
        #1;
        check("flush_blocks", 64'(bus.issue_ready),  64'h0);
        check("flush_mem_rdy", 64'(bus.mem_wb_ready), 64'h1);
        tick();
        bus.flush        = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.mem_wb_valid = 1'b0;
        check("flush_busy",   64'(bus.busy),         64'h0);
        check("flush_wb_we",  64'(bus.rf_reg_write), 64'h1);
        check("flush_wb_rd",  64'(bus.rf_rd),        64'h3);
        check("flush_no_err", 64'(bus.wb_err),       64'h0);
        bus.mem_wb_valid = 1'b1;
        bus.mem_wb_rd    = 5'd7;
        bus.mem_wb_data  = 64'h77;
        tick();
        bus.mem_wb_valid = 1'b0;
        check("post_flush_rd",     64'(bus.rf_rd),  64'h7);
        check("post_flush_no_err", 64'(bus.wb_err), 64'h0);
        bus.alu_wb_valid = 1'b1;
        bus.alu_wb_rd    = 5'd3;
        bus.alu_wb_data  = 64'h34;
        tick();
        bus.alu_wb_valid = 1'b0;
        check("late_wb_we",  64'(bus.rf_reg_write), 64'h1);
        check("late_wb_err", 64'(bus.wb_err),       64'h1);
        tick();
        check("idle_we",     64'(bus.rf_reg_write), 64'h0);
        check("err_sticky",  64'(bus.wb_err),       64'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 64, data width of the write-back path and register file.
REQ-002 Parameter NREG, default 32, number of architectural registers; the register index is 5 bits.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 issue_valid  in  1  decode presents an instruction.
REQ-006 issue_rs1, issue_rs2, issue_rd  in  5 each  source and destination register indices.
REQ-007 issue_ready  out  1  no hazard; the instruction issues when issue_valid and issue_ready are both high.
REQ-008 alu_wb_valid  in  1; alu_wb_rd  in  5; alu_wb_data  in  XLEN  ALU write-back request.
REQ-009 alu_wb_ready  out  1  ALU request accepted this cycle.
REQ-010 mem_wb_valid  in  1; mem_wb_rd  in  5; mem_wb_data  in  XLEN  load-unit write-back request.
REQ-011 mem_wb_ready  out  1  load request accepted this cycle.
REQ-012 flush  in  1  pipeline flush.
REQ-013 rf_reg_write  out  1; rf_rd  out  5; rf_write_data  out  XLEN  registered drive of the register file write port.
REQ-014 busy  out  NREG  scoreboard; bit i set means register i has a write pending.
REQ-015 wb_err  out  1  sticky flag: a write-back arrived for a register that was not busy.

Function
REQ-016 Arbitration: the block SHALL accept at most one write-back request per cycle.
REQ-017 A lone valid request SHALL be accepted in the same cycle; its ready is combinational.
REQ-018 When both requesters are valid, the requester selected by rr_ptr SHALL be accepted (rr_ptr 0 = ALU, 1 = MEM); rr_ptr then flips to point at the loser.
REQ-019 rr_ptr SHALL be unchanged in cycles without a conflict.
REQ-020 An accepted request SHALL appear on rf_rd and rf_write_data on the next cycle, with rf_reg_write=1 only if rd!=0 (one-cycle latency).
REQ-021 rf_reg_write SHALL be 0 in any cycle that follows a cycle with no acceptance.
REQ-022 Scoreboard: issue_ready SHALL be 0 when busy[rs1], busy[rs2] or busy[rd] is set (RAW and WAW hazards), or when flush=1; index 0 is never treated as busy.
REQ-023 An issue with rd!=0 SHALL set busy[rd] at the next edge.
REQ-024 busy[rf_rd] SHALL clear at the edge that ends the cycle in which rf_reg_write=1; there is no bypass, so a dependent instruction issues in the cycle after that edge at the earliest.
REQ-025 busy[0] SHALL always read 0.
REQ-026 flush=1 SHALL clear all busy bits at the next edge and block issue that cycle.
REQ-027 Write-backs SHALL still be accepted and written during and after a flush, and these writes SHALL NOT set wb_err.
REQ-028 An accepted write-back with rd!=0 whose busy[rd]=0 at acceptance, in a cycle more than one cycle after the last flush, SHALL set wb_err; wb_err stays set until reset.
REQ-029 Set-busy and clear-busy of different registers in the same cycle SHALL both take effect.

Reset
REQ-030 While rst_n=0: busy=0, rr_ptr=0, rf_reg_write=0, rf_rd=0, rf_write_data=0, wb_err=0; this takes effect asynchronously, mid-operation included.
REQ-031 A write-back accepted in the cycle reset asserts SHALL be discarded.
REQ-032 The first edge with rst_n=1 SHALL operate normally.

Verification
REQ-033 Issue rd=5 -> busy[5]=1. Then ALU write-back rd=5, data 0xAB -> the next cycle shows rf_reg_write=1, rf_rd=5, data 0xAB; busy[5]=0 one edge later.
REQ-034 Issue with rs1=5 while busy[5]=1 -> issue_ready=0 until the cycle after the write of register 5, then 1.
REQ-035 ALU and MEM both valid for 4 cycles after reset -> grants go ALU, MEM, ALU, MEM, with each rf_rd matching the granted requester.
REQ-036 Write-back to rd=0 -> the request is accepted, rf_reg_write=0, busy is unchanged and wb_err stays 0.
REQ-037 busy[3] and busy[7] set, flush pulsed -> busy=0 after one edge. A later write-back to 3 more than one cycle after the flush -> wb_err=1.
REQ-038 rst_n low mid-stream while a write is pending -> rf_reg_write=0 and busy=0 immediately, without waiting for a clock edge.
